// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// One access is staged per cycle; reads return two cycles after acceptance.
module data_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic [15:0]   conflict_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } stage_t;

  state_t        state, state_nxt;
  stage_t        stg;
  logic          rr_last;
  logic          accept;
  logic          rd_vld, rd_port;
  logic [DW-1:0] rdata0, rdata1;
  logic [15:0]   cnt;

  // On a tie the port that was not granted last wins.
  always_comb begin
    p0_gnt = ~reset & p0_req & (~p1_req | rr_last);
    p1_gnt = ~reset & p1_req & (~p0_req | ~rr_last);
    accept = p0_gnt | p1_gnt;
  end

  // ACTIVE doubles as the stage-valid bit; outputs are gated by reset so a
  // staged write is dropped the moment reset rises.
  always_comb begin
    state_nxt = IDLE;
    mem_a     = '0;
    mem_wd    = '0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (accept) state_nxt = ACTIVE;
        if (!reset) begin
          mem_a  = stg.addr;
          mem_wd = stg.wdata;
          mem_we = stg.we;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      stg.port  <= p1_gnt;
      stg.we    <= p1_gnt ? p1_we    : p0_we;
      stg.addr  <= p1_gnt ? p1_addr  : p0_addr;
      stg.wdata <= p1_gnt ? p1_wdata : p0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       rr_last <= 1'b1;
    else if (accept) rr_last <= p1_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld  <= 1'b0;
      rd_port <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rd_vld  <= (state == ACTIVE) && !stg.we;
      rd_port <= stg.port;
      if ((state == ACTIVE) && !stg.we) begin
        if (stg.port) rdata1 <= mem_rd;
        else          rdata0 <= mem_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                              cnt <= '0;
    else if (p0_req && p1_req && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end

  always_comb begin
    p0_rvalid    = ~reset & rd_vld & ~rd_port;
    p1_rvalid    = ~reset & rd_vld & rd_port;
    p0_rdata     = reset ? '0 : rdata0;
    p1_rdata     = reset ? '0 : rdata1;
    conflict_cnt = reset ? '0 : cnt;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 p0_req / p1_req  input  1  access request, port 0 (processor) / port 1 (debug/loader).
REQ-006 p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-007 p0_addr / p1_addr  input  AW  byte address.
REQ-008 p0_wdata / p1_wdata  input  DW  write data.
REQ-009 p0_gnt / p1_gnt  output  1  request accepted at this clock edge.
REQ-010 p0_rvalid / p1_rvalid  output  1  one-cycle pulse: read data valid.
REQ-011 p0_rdata / p1_rdata  output  DW  read data, meaningful only while the matching rvalid is high.
REQ-012 mem_a  output  AW  address to the data memory.
REQ-013 mem_wd  output  DW  write data to the data memory.
REQ-014 mem_we  output  1  memory write enable; the memory writes on the rising clk edge.
REQ-015 mem_rd  input  DW  memory read data, combinational from mem_a.
REQ-016 conflict_cnt  output  16  saturating count of cycles with both requests high.

Function
REQ-017 Grants are combinational from the current requests and rr_last; at most one of p0_gnt/p1_gnt is high in any cycle.
REQ-018 A request is accepted at an edge where req && gnt; the requester holds req, we, addr and wdata stable until accepted.
REQ-019 A single requester is granted in the same cycle, with no idle cycle.
REQ-020 Both requesting: grant goes to the port that is not rr_last; rr_last updates to the granted port on every acceptance.
REQ-021 One acceptance per cycle; full throughput, with back-to-back acceptances allowed.
REQ-022 Stage register: an acceptance at edge ending cycle N loads {valid, port, we, addr, wdata}; during cycle N+1 the block drives mem_a=addr, mem_wd=wdata and mem_we=we.
REQ-023 Write: the memory updates at the edge ending N+1; no rvalid is produced.
REQ-024 Read: mem_rd is registered at the edge ending N+1; the owning port's rvalid is high for exactly cycle N+2 with rdata; the other port's rvalid stays 0.
REQ-025 Read latency is 2 cycles from acceptance, in order per port.
REQ-026 Write then read to the same address in consecutive acceptances returns the new data, because the write completes before the read's memory cycle.
REQ-027 Stage empty: mem_we=0, mem_a=0, mem_wd=0.
REQ-028 rdata holds its last value between rvalid pulses.
REQ-029 conflict_cnt increments by 1 in each cycle where p0_req && p1_req, and saturates at 16'hFFFF without wrapping.
REQ-030 State machine IDLE/ACTIVE: IDLE means the stage is empty; a transition to ACTIVE occurs on acceptance; ACTIVE stays ACTIVE while acceptances continue and returns to IDLE otherwise.

Reset
REQ-031 While reset=1: both gnt=0, both rvalid=0, stage valid=0, mem_we=0, mem_a=0, mem_wd=0, rdata=0, conflict_cnt=0, rr_last=1 (so port 0 wins the first tie), state IDLE.
REQ-032 Reset asserted mid-operation discards the staged access (no memory write in the following cycle) and any pending rvalid.
REQ-033 Requests presented during reset are not accepted; arbitration resumes in the first cycle after reset deasserts.

Verification
REQ-034 Port 0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> p0_gnt in the same cycle each time; mem_we=1 one cycle after the write is accepted; p0_rvalid=1 with rdata=0xDEADBEEF two cycles after the read is accepted.
REQ-035 Both ports hold read requests for 4 cycles after reset -> grants go P0,P1,P0,P1; conflict_cnt=4; each rvalid lands on the correct port with the correct data.
REQ-036 p1 writes 0x5 to 0x20 and p0 reads 0x20 in the next cycle -> p0_rdata=0x5.
REQ-037 Reset raised the cycle after a write is accepted -> mem_we stays 0; memory contents unchanged; no rvalid.
REQ-038 Force p0_req=p1_req=1 for 70000 cycles -> conflict_cnt=0xFFFF with no wrap; grants still strictly alternate.
REQ-039 Random req/we/addr on both ports against a reference memory model -> every read returns model data, exactly one rvalid per accepted read, never two gnts in one cycle.
